pe_row_q: RTL

- Next-generation 1-D systolic PE row, parametrised successor of the 8-bit/20-bit row.
- ARRAY_NUM signed MAC lanes. Weights and clear-accumulate tokens ripple lane to lane with one cycle per lane.
- Per-lane input data comes either from the parallel bus or from a left-pass chain.
- Adds a global stall (iEn), a round-half-up arithmetic-right-shift quantiser with signed saturation, and per-lane oResultValid registered together with oResult.
- Sits between the data/weight feeders and the output writeback in each cube slice.

---
 rtl/pe_pkg.sv | 29 ++
 rtl/pe_mac.sv | 52 +++++
 rtl/pe_row_q.sv | 109 ++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared widths, lane slicing helper and round/saturate quantiser for the PE row
package pe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;
  localparam int QW         = 64;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // acc arrives sign-extended to QW bits and s never exceeds the accumulator msb index,
  // so the wide sum below cannot overflow and matches an ACC_W+1 bit computation.
  function automatic logic signed [QW-1:0] quantise(
    input logic signed [QW-1:0] acc,
    input int                   s,
    input int                   data_w
  );
    logic signed [QW-1:0] rnd, r, hi, lo;
    rnd = (s > 0) ? (64'sd1 <<< (s - 1)) : 64'sd0;
    r   = (acc + rnd) >>> s;
    hi  = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - one systolic MAC lane: weight/clear pipeline stage and wrapping accumulator
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] weight_i,
  input  logic              clear_i,
  output logic [DATA_W-1:0] weight_o,
  output logic              clear_o,
  output logic [ACC_W-1:0]  acc_o,
  output logic              capture_o
);

  logic [DATA_W-1:0]          weight_q;
  logic                       clear_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    prod;
  logic signed [2*DATA_W-1:0] prod_full;

  assign prod_full = $signed(data_i) * $signed(weight_i);
  assign prod      = ACC_W'(prod_full);

  // A clear token starts the next vector with this cycle's product; the old sum leaves via acc_o.
  always_comb begin
    acc_d = clear_i ? prod : acc_q + prod;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      weight_q <= '0;
      clear_q  <= 1'b0;
      acc_q    <= '0;
    end else if (en_i) begin
      weight_q <= weight_i;
      clear_q  <= clear_i;
      acc_q    <= acc_d;
    end
  end

  assign weight_o  = weight_q;
  assign clear_o   = clear_q;
  assign acc_o     = acc_q;
  assign capture_o = en_i & clear_i;

endmodule

// File: rtl/pe_row_q.sv
// rtl/pe_row_q.sv - 1-D systolic PE row with left-pass data chain, stall and per-lane quantiser
module pe_row_q
  import pe_pkg::*;
#(
  parameter int ARRAY_NUM = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int SHIFT_W   = 5
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic                        iEn,
  input  logic                        iClearAcc,
  input  logic [ARRAY_NUM-2:0]        iCfsPassDataLeft,
  input  logic [DATA_W*ARRAY_NUM-1:0] iData,
  input  logic [DATA_W-1:0]           iWeight,
  input  logic [SHIFT_W-1:0]          iCfsShift,
  output logic [DATA_W-1:0]           oWeight,
  output logic                        oClearAcc,
  output logic [DATA_W*ARRAY_NUM-1:0] oResult,
  output logic [ARRAY_NUM-1:0]        oResultValid
);

  logic [DATA_W-1:0]               data_cache_q [ARRAY_NUM];
  logic [DATA_W-1:0]               data_dly_q   [1:ARRAY_NUM-1];
  logic [ARRAY_NUM:0][DATA_W-1:0]  w_chain;
  logic [ARRAY_NUM:0]              c_chain;
  logic [ARRAY_NUM-1:0][ACC_W-1:0] acc_lane;
  logic [ARRAY_NUM-1:0]            capture;
  logic [DATA_W*ARRAY_NUM-1:0]     quant;
  logic [DATA_W*ARRAY_NUM-1:0]     result_q, result_d;
  logic [ARRAY_NUM-1:0]            valid_q, valid_d;
  logic [DATA_W:0]                 unused_tail;
  int                              shift_sat;

  // Chained data spends one cycle in the cache and one in the delay stage of every lane.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < ARRAY_NUM; i++) data_cache_q[i] <= '0;
      for (int i = 1; i < ARRAY_NUM; i++) data_dly_q[i] <= '0;
    end else if (iEn) begin
      data_cache_q[ARRAY_NUM-1] <= iData[lane_lo(ARRAY_NUM-1, DATA_W) +: DATA_W];
      for (int i = 0; i < ARRAY_NUM-1; i++) begin
        data_cache_q[i] <= iCfsPassDataLeft[i] ? data_dly_q[i+1]
                                               : iData[lane_lo(i, DATA_W) +: DATA_W];
      end
      for (int i = 1; i < ARRAY_NUM; i++) data_dly_q[i] <= data_cache_q[i];
    end
  end

  always_comb begin
    shift_sat = int'(iCfsShift);
    if (shift_sat > ACC_W - 1) shift_sat = ACC_W - 1;
  end

  assign w_chain[0] = iWeight;
  assign c_chain[0] = iClearAcc;

  for (genvar i = 0; i < ARRAY_NUM; i++) begin : g_lane
    pe_mac #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_mac (
      .clk_i    (iClk),
      .rst_i    (iRst),
      .en_i     (iEn),
      .data_i   (data_cache_q[i]),
      .weight_i (w_chain[i]),
      .clear_i  (c_chain[i]),
      .weight_o (w_chain[i+1]),
      .clear_o  (c_chain[i+1]),
      .acc_o    (acc_lane[i]),
      .capture_o(capture[i])
    );

    assign quant[lane_lo(i, DATA_W) +: DATA_W] =
      DATA_W'(quantise(QW'($signed(acc_lane[i])), shift_sat, DATA_W));
  end

  // The last lane's forwarded weight/clear have nowhere to go inside the row.
  assign unused_tail = {w_chain[ARRAY_NUM], c_chain[ARRAY_NUM]};

  always_comb begin
    result_d = result_q;
    valid_d  = '0;
    for (int i = 0; i < ARRAY_NUM; i++) begin
      if (capture[i]) begin
        result_d[lane_lo(i, DATA_W) +: DATA_W] = quant[lane_lo(i, DATA_W) +: DATA_W];
        valid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      result_q <= '0;
      valid_q  <= '0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign oWeight      = w_chain[1];
  assign oClearAcc    = c_chain[1];
  assign oResult      = result_q;
  assign oResultValid = valid_q;

endmodule
